intersection_controller: RTL and testbench

//  Supervises the two per-approach light state machines (north-south, east-west) at one intersection.

---
 rtl/intersection_controller_pkg.sv | 16 +
 rtl/intersection_controller_if.sv | 32 +++
 rtl/intersection_controller_conflict_filter.sv | 17 +
 rtl/intersection_controller.sv | 72 +++++++
 tb/tb_intersection_controller.sv | 124 ++++++++++++
 5 files changed

// File: rtl/intersection_controller_pkg.sv
// intersection_controller_pkg: shared state codes, fault codes and light-machine reset targets
package intersection_controller_pkg;
  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    FAULT   = 2'd2,
    RECOVER = 2'd3
  } ctrl_state_t;
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_CONFLICT = 2'b01,
    FAULT_MAINT    = 2'b10
  } fault_code_t;
  localparam logic RESET_TO_RED             = 1'b0;
  localparam logic RESET_TO_GREEN_LEFT_TURN = 1'b1;
endpackage

// File: rtl/intersection_controller_if.sv
// intersection_controller_if: light-state inputs, operator controls and light-machine drives
interface intersection_controller_if;
  logic       in_fault_clear;
  logic       in_force_flash;
  logic       in_ns_green;
  logic       in_ns_yellow;
  logic       in_ns_left;
  logic       in_ew_green;
  logic       in_ew_yellow;
  logic       in_ew_left;
  logic       out_ns_reset;
  logic       out_ns_reset_state;
  logic       out_ns_issue;
  logic       out_ew_reset;
  logic       out_ew_reset_state;
  logic       out_ew_issue;
  logic       out_fault;
  logic [1:0] out_fault_code;
  logic [1:0] out_state;
  modport master (
    output in_fault_clear, in_force_flash, in_ns_green, in_ns_yellow, in_ns_left,
           in_ew_green, in_ew_yellow, in_ew_left,
    input  out_ns_reset, out_ns_reset_state, out_ns_issue, out_ew_reset, out_ew_reset_state,
           out_ew_issue, out_fault, out_fault_code, out_state
  );
  modport slave (
    input  in_fault_clear, in_force_flash, in_ns_green, in_ns_yellow, in_ns_left,
           in_ew_green, in_ew_yellow, in_ew_left,
    output out_ns_reset, out_ns_reset_state, out_ns_issue, out_ew_reset, out_ew_reset_state,
           out_ew_issue, out_fault, out_fault_code, out_state
  );
endinterface

// File: rtl/intersection_controller_conflict_filter.sv
// intersection_controller_conflict_filter: saturating debounce of the conflict signal, cleared when disabled
module intersection_controller_conflict_filter #(
  parameter int TICKS = 3
) (
  input  logic in_clock,
  input  logic in_reset_n,
  input  logic in_enable,
  input  logic in_conflict,
  output logic out_trip
);
  logic [31:0] count;
  assign out_trip = in_enable & in_conflict & (count == 32'(TICKS - 1));
  always_ff @(posedge in_clock) begin
    if (!in_reset_n || !in_enable || !in_conflict) count <= '0;
    else if (~&count) count <= count + 32'd1;
  end
endmodule

// File: rtl/intersection_controller.sv
// intersection_controller: sequences NS/EW light-machine resets and forces flashing red on conflict or maintenance
module intersection_controller
  import intersection_controller_pkg::*;
#(
  parameter int RESET_HOLD_TICKS      = 5,
  parameter int CONFLICT_FILTER_TICKS = 3
) (
  input logic                      in_clock,
  input logic                      in_reset_n,
  intersection_controller_if.slave bus
);
  ctrl_state_t state, next_state;
  fault_code_t code, next_code;
  logic [31:0] count;
  logic        lights_reset, fault_r, conflict, trip, hold_done;
  assign conflict  = (bus.in_ns_green | bus.in_ns_yellow | bus.in_ns_left) &
                     (bus.in_ew_green | bus.in_ew_yellow | bus.in_ew_left);
  assign hold_done = count == 32'(RESET_HOLD_TICKS - 1);
  intersection_controller_conflict_filter #(.TICKS(CONFLICT_FILTER_TICKS)) u_filter (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_enable  (state == RUN),
    .in_conflict(conflict),
    .out_trip   (trip)
  );
  always_comb begin
    next_state = state;
    next_code  = code;
    case (state)
      INIT: next_state = hold_done ? RUN : INIT;
      RUN:
        if (trip) begin
          next_state = FAULT;
          next_code  = FAULT_CONFLICT;
        end else if (bus.in_force_flash) begin
          next_state = FAULT;
          next_code  = FAULT_MAINT;
        end
      FAULT: next_state = (bus.in_fault_clear && !bus.in_force_flash) ? RECOVER : FAULT;
      RECOVER:
        if (bus.in_force_flash) begin
          next_state = FAULT;
          next_code  = FAULT_MAINT;
        end else if (hold_done) next_state = RUN;
    endcase
  end
  // Outputs are registered from next_state so they switch on the same edge as the state.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      state        <= INIT;
      code         <= FAULT_NONE;
      count        <= '0;
      lights_reset <= 1'b1;
      fault_r      <= 1'b0;
    end else begin
      state        <= next_state;
      code         <= next_code;
      count        <= (next_state != state) ? '0 : (&count ? count : count + 32'd1);
      lights_reset <= (next_state == INIT) || (next_state == RECOVER);
      fault_r      <= next_state == FAULT;
    end
  end
  assign bus.out_ns_reset       = lights_reset;
  assign bus.out_ew_reset       = lights_reset;
  assign bus.out_ns_reset_state = RESET_TO_GREEN_LEFT_TURN;
  assign bus.out_ew_reset_state = RESET_TO_RED;
  assign bus.out_ns_issue       = fault_r;
  assign bus.out_ew_issue       = fault_r;
  assign bus.out_fault          = fault_r;
  assign bus.out_fault_code     = code;
  assign bus.out_state          = state;
endmodule

// File: tb/tb_intersection_controller.sv
// tb_intersection_controller: directed stimulus queues expected outputs; a monitor pops and compares each cycle
module tb_intersection_controller;
  import intersection_controller_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails = 0;
  logic [10:0] exp_q[$];
  string       name_q[$];
  logic [10:0] e_m, a_m;
  string       n_m;
  intersection_controller_if bus ();
  intersection_controller dut (
    .in_clock  (clk),
    .in_reset_n(rst_n),
    .bus       (bus)
  );
  always #5 clk = ~clk;
  // Expected outputs per state: resets high in INIT/RECOVER, issue and fault high only in FAULT.
  task automatic tick(input ctrl_state_t s, input fault_code_t c, input string nm);
    logic r, f;
    r = (s == INIT) || (s == RECOVER);
    f = s == FAULT;
    exp_q.push_back({r, r, 1'b1, 1'b0, f, f, f, 2'(c), 2'(s)});
    name_q.push_back(nm);
    @(negedge clk);
  endtask
  task automatic ticks(input int n, input ctrl_state_t s, input fault_code_t c, input string nm);
    for (int k = 0; k < n; k++) tick(s, c, nm);
  endtask
  task automatic conf(input logic v);
    bus.in_ns_green = v;
    bus.in_ew_left  = v;
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e_m = exp_q.pop_front();
      n_m = name_q.pop_front();
      a_m = {bus.out_ns_reset, bus.out_ew_reset, bus.out_ns_reset_state, bus.out_ew_reset_state,
             bus.out_ns_issue, bus.out_ew_issue, bus.out_fault, bus.out_fault_code, bus.out_state};
      checks++;
      if (a_m !== e_m) begin
        fails++;
        $display("FAIL %s: got %b expected %b (rst rst rs_ns rs_ew iss iss flt code state)", n_m, a_m, e_m);
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    bus.in_fault_clear = 1'b0;
    bus.in_force_flash = 1'b0;
    bus.in_ns_green = 1'b0;
    bus.in_ns_yellow = 1'b0;
    bus.in_ns_left = 1'b0;
    bus.in_ew_green = 1'b0;
    bus.in_ew_yellow = 1'b0;
    bus.in_ew_left = 1'b0;
    @(negedge clk);
    ticks(2, INIT, FAULT_NONE, "reset");
    rst_n = 1'b1;
    ticks(4, INIT, FAULT_NONE, "init_hold");
    tick(RUN, FAULT_NONE, "init_release");
    bus.in_ns_yellow = 1'b1;
    ticks(3, RUN, FAULT_NONE, "ns_only");
    bus.in_ns_yellow = 1'b0;
    bus.in_ew_green = 1'b1;
    ticks(3, RUN, FAULT_NONE, "ew_only");
    bus.in_ew_green = 1'b0;
    conf(1'b1);
    ticks(2, RUN, FAULT_NONE, "conflict_short");
    conf(1'b0);
    tick(RUN, FAULT_NONE, "conflict_gap");
    conf(1'b1);
    ticks(2, RUN, FAULT_NONE, "conflict_build");
    tick(FAULT, FAULT_CONFLICT, "conflict_trip");
    conf(1'b0);
    tick(FAULT, FAULT_CONFLICT, "fault_hold");
    bus.in_fault_clear = 1'b1;
    tick(RECOVER, FAULT_CONFLICT, "clear_conflict");
    bus.in_fault_clear = 1'b0;
    ticks(4, RECOVER, FAULT_CONFLICT, "recover_hold");
    tick(RUN, FAULT_CONFLICT, "recover_done");
    bus.in_fault_clear = 1'b1;
    tick(RUN, FAULT_CONFLICT, "clear_in_run");
    bus.in_fault_clear = 1'b0;
    bus.in_force_flash = 1'b1;
    tick(FAULT, FAULT_MAINT, "maint");
    bus.in_fault_clear = 1'b1;
    ticks(2, FAULT, FAULT_MAINT, "clear_blocked");
    bus.in_force_flash = 1'b0;
    tick(RECOVER, FAULT_MAINT, "clear_maint");
    bus.in_fault_clear = 1'b0;
    ticks(4, RECOVER, FAULT_MAINT, "recover_hold2");
    tick(RUN, FAULT_MAINT, "recover_done2");
    conf(1'b1);
    ticks(2, RUN, FAULT_MAINT, "simul_build");
    bus.in_force_flash = 1'b1;
    tick(FAULT, FAULT_CONFLICT, "simul_priority");
    conf(1'b0);
    bus.in_force_flash = 1'b0;
    bus.in_fault_clear = 1'b1;
    tick(RECOVER, FAULT_CONFLICT, "abort_enter");
    bus.in_fault_clear = 1'b0;
    tick(RECOVER, FAULT_CONFLICT, "abort_cycle1");
    bus.in_force_flash = 1'b1;
    tick(FAULT, FAULT_MAINT, "recover_abort");
    bus.in_force_flash = 1'b0;
    tick(FAULT, FAULT_MAINT, "abort_hold");
    rst_n = 1'b0;
    tick(INIT, FAULT_NONE, "reset_mid_fault");
    rst_n = 1'b1;
    ticks(4, INIT, FAULT_NONE, "reinit_hold");
    tick(RUN, FAULT_NONE, "reinit_release");
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
